sweep_controller: RTL and testbench
===================================

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 Parameter POS_MAX, default 180, last sweep position; positions run 0..POS_MAX.
REQ-002 Parameter STEP, default 1, position increment per sweep step.
REQ-003 Parameter SETTLE_CYC, default 1000, wait cycles after every position change before sampling.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that launches a sweep.
REQ-007 abort  in  1  level; stops the sweep at the current position.
REQ-008 adc_req  out  1  sample request to the ADC.
REQ-009 adc_ack  in  1  one-cycle pulse; adc_data is valid in the same cycle.
REQ-010 adc_data  in  12  ADC sample, unsigned.
REQ-011 pos  out  8  commanded actuator position.
REQ-012 best_pos  out  8  position of the maximum sample.
REQ-013 best_val  out  12  maximum sample.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-016 FSM states: IDLE, HOME, SETTLE, SAMPLE, COMPARE, STEP, GOTO_BEST, DONE.
REQ-017 IDLE: start=1 -> HOME. start is ignored in every other state.
REQ-018 HOME: pos<=0, first_flag<=1, load the settle counter -> SETTLE.
REQ-019 SETTLE: the counter decrements once per cycle and exits after exactly SETTLE_CYC cycles. Exit goes to SAMPLE on the sweep pass, or to DONE when entered from GOTO_BEST.
REQ-020 SAMPLE: adc_req is held high until the adc_ack cycle; adc_data is captured on ack; adc_req is low in the cycle after ack -> COMPARE.
REQ-021 COMPARE: the sample wins if first_flag=1, or if sample[11:6] > best_val[11:6]. Comparison is unsigned; bits [5:0] are ignored.
REQ-022 On a win, best_val<=sample and best_pos<=pos, and first_flag clears. On a tie or a lower sample the earlier position is kept.
REQ-023 COMPARE exit: -> STEP if pos+STEP <= POS_MAX, otherwise -> GOTO_BEST. The computation is 9-bit, so pos never wraps past 255.
REQ-024 STEP: pos<=pos+STEP, load the settle counter -> SETTLE.
REQ-025 GOTO_BEST: pos<=best_pos, load the settle counter -> SETTLE.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE. best_pos and best_val hold until the next HOME.
REQ-027 A start in the DONE cycle is ignored.
REQ-028 abort=1 in any non-IDLE state -> IDLE on the next edge. adc_req drops, pos holds, best_* hold, and done is not pulsed.
REQ-029 abort has priority over adc_ack in the same cycle; that sample is discarded.
REQ-030 Per-position latency, from the STEP cycle to the COMPARE cycle, is 1 + SETTLE_CYC + ADC wait + 1 cycles.

Reset
REQ-031 While rst_n=0, all outputs and state are forced asynchronously: state=IDLE, pos=0, best_pos=0, best_val=0, adc_req=0, busy=0, done=0, first_flag=0, settle counter=0.
REQ-032 Reset deassertion is synchronised externally. Reset asserted mid-sweep aborts without a done pulse.

Structure
REQ-033 The shared package holds the FSM state encoding, ADC_W=12, POS_W=8, and CMP_MSB=11 / CMP_LSB=6 (the compared bit field).
REQ-034 One sub-module is used: settle_timer, a loadable down-counter with load, count, and a zero flag; width is $clog2(SETTLE_CYC+1).
REQ-035 The compare is inline and uses the package bit-field constants.

Verification (SETTLE_CYC=4, POS_MAX=4, STEP=1 unless stated)
REQ-036 Ramp 100,200,300,400,500 at pos 0..4 -> best_val=500, best_pos=4, pos ends at 4, done pulses once.
REQ-037 Samples 0x0C0,0x0FF,0x040,0x0C0,0x000 -> best_pos=0, best_val=0x0C0: 0x0FF ties in [11:6], and the second 0x0C0 is a tie.
REQ-038 All samples 0 -> first sample wins via first_flag -> best_pos=0, best_val=0.
REQ-039 abort during SAMPLE at pos=2, coincident with adc_ack -> next cycle state=IDLE, busy=0, adc_req=0, pos=2, no done pulse.
REQ-040 STEP=3, POS_MAX=4 -> positions sampled are 0 and 3 only; no wrap.
REQ-041 rst_n low mid-SETTLE -> all outputs 0 immediately, without a clock edge.
REQ-042 start held high through a whole sweep -> exactly one sweep.

Source files
------------

// File: rtl/sweep_controller_pkg.sv
// sweep_controller_pkg: shared FSM encoding and widths for the position sweep controller.
package sweep_controller_pkg;
    localparam int ADC_W   = 12;
    localparam int POS_W   = 8;
    localparam int CMP_MSB = 11;
    localparam int CMP_LSB = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOME,
        S_SETTLE,
        S_SAMPLE,
        S_COMPARE,
        S_STEP,
        S_GOTO_BEST,
        S_DONE
    } state_t;
endpackage

// File: rtl/sweep_controller_settle_timer.sv
// settle_timer: loadable down-counter that stops at zero and flags it.
module settle_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_count,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (i_count && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/sweep_controller.sv
// sweep_controller: steps an actuator across 0..POS_MAX, samples an ADC after settling
// at each position, and parks on the position whose sample was largest.
module sweep_controller
    import sweep_controller_pkg::*;
#(
    parameter int POS_MAX    = 180,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_adc_req,
    input  logic             i_adc_ack,
    input  logic [ADC_W-1:0] i_adc_data,
    output logic [POS_W-1:0] o_pos,
    output logic [POS_W-1:0] o_best_pos,
    output logic [ADC_W-1:0] o_best_val,
    output logic             o_busy,
    output logic             o_done
);
    localparam int TW  = $clog2(SETTLE_CYC + 1);
    localparam int PW1 = POS_W + 1;
    // The timer reaches zero in the last settle cycle, so load one less than the wait.
    localparam logic [TW-1:0]  LOAD_VAL = TW'(SETTLE_CYC - 1);
    localparam logic [PW1-1:0] STEP_9   = PW1'(STEP);
    localparam logic [PW1-1:0] MAX_9    = PW1'(POS_MAX);

    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic [POS_W-1:0]   r_best_pos;
    logic [ADC_W-1:0]   r_best_val;
    logic [ADC_W-1:0]   r_sample;
    logic               r_adc_req;
    logic               r_busy;
    logic               r_done;
    logic               r_first;
    logic               r_return;
    logic               w_load;
    logic               w_zero;
    logic               w_win;
    logic [PW1-1:0]     w_pos_next;

    assign w_load     = (r_state == S_HOME) || (r_state == S_STEP) || (r_state == S_GOTO_BEST);
    assign w_pos_next = {1'b0, r_pos} + STEP_9;
    assign w_win      = r_first || (r_sample[CMP_MSB:CMP_LSB] > r_best_val[CMP_MSB:CMP_LSB]);

    settle_timer #(.W(TW)) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_value (LOAD_VAL),
        .i_count (r_state == S_SETTLE),
        .o_zero  (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pos      <= '0;
            r_best_pos <= '0;
            r_best_val <= '0;
            r_sample   <= '0;
            r_adc_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_first    <= 1'b0;
            r_return   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && r_state != S_IDLE) begin
                r_state   <= S_IDLE;
                r_adc_req <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state <= S_HOME;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_HOME: begin
                        r_pos    <= '0;
                        r_first  <= 1'b1;
                        r_return <= 1'b0;
                        r_state  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (w_zero) begin
                            r_state   <= r_return ? S_DONE : S_SAMPLE;
                            r_adc_req <= !r_return;
                            r_done    <= r_return;
                        end
                    end
                    S_SAMPLE: begin
                        if (i_adc_ack) begin
                            r_sample  <= i_adc_data;
                            r_adc_req <= 1'b0;
                            r_state   <= S_COMPARE;
                        end
                    end
                    S_COMPARE: begin
                        if (w_win) begin
                            r_best_val <= r_sample;
                            r_best_pos <= r_pos;
                            r_first    <= 1'b0;
                        end
                        r_state <= (w_pos_next <= MAX_9) ? S_STEP : S_GOTO_BEST;
                    end
                    S_STEP: begin
                        r_pos   <= w_pos_next[POS_W-1:0];
                        r_state <= S_SETTLE;
                    end
                    S_GOTO_BEST: begin
                        r_pos    <= r_best_pos;
                        r_return <= 1'b1;
                        r_state  <= S_SETTLE;
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_adc_req  = r_adc_req;
    assign o_pos      = r_pos;
    assign o_best_pos = r_best_pos;
    assign o_best_val = r_best_val;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
endmodule

// File: tb/tb_sweep_controller.sv
// tb_sweep_controller: two controllers (STEP=1 and STEP=3) driven by random ADC responders,
// checked against a behavioural max-search model through per-channel scoreboards.
module tb_sweep_controller;
    localparam int SC = 4;
    localparam int PM = 4;

    typedef struct {
        int bp;
        int bv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [2];
    logic        adc_req [2];
    logic        busy [2];
    logic        done [2];
    logic [7:0]  pos [2];
    logic [7:0]  best_pos [2];
    logic [11:0] best_val [2];
    logic [11:0] samp [2][256];
    int          abort_pos [2];
    int          q_pos [2][$];
    exp_t        q_exp [2][$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        logic        abort = 1'b0;
        logic        adc_ack = 1'b0;
        logic [11:0] adc_data = '0;
        int          gap = 0;
        int          wait_left = -1;
        bit          fresh = 1'b1;

        sweep_controller #(.POS_MAX(PM), .STEP(g == 0 ? 1 : 3), .SETTLE_CYC(SC)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_start    (start[g]),
            .i_abort    (abort),
            .o_adc_req  (adc_req[g]),
            .i_adc_ack  (adc_ack),
            .i_adc_data (adc_data),
            .o_pos      (pos[g]),
            .o_best_pos (best_pos[g]),
            .o_best_val (best_val[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g])
        );

        // ADC responder: answers each request after a random delay and checks settle latency.
        always @(negedge clk) begin
            adc_ack = 1'b0;
            abort = 1'b0;
            if (!rst_n || !busy[g]) begin
                gap = 0;
                fresh = 1'b1;
                wait_left = -1;
            end else if (adc_req[g]) begin
                if (wait_left < 0) begin
                    check($sformatf("ch%0d_settle_gap", g), gap, fresh ? SC + 1 : SC + 2);
                    fresh = 1'b0;
                    if (q_pos[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ch%0d_req_pos: unexpected request at pos %0d", g, pos[g]);
                    end else
                        check($sformatf("ch%0d_req_pos", g), int'(pos[g]), q_pos[g].pop_front());
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    adc_ack = 1'b1;
                    adc_data = samp[g][pos[g]];
                    abort = (int'(pos[g]) == abort_pos[g]);
                    wait_left = -1;
                    gap = 0;
                end else
                    wait_left--;
            end else
                gap++;
        end

        // Result monitor: every done pulse must match the next expected sweep result.
        always @(negedge clk) begin
            if (rst_n && done[g]) begin
                if (q_exp[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ch%0d_done: unexpected done pulse, got 1 expected 0", g);
                end else begin
                    exp_t e;
                    e = q_exp[g].pop_front();
                    check($sformatf("ch%0d_best_pos", g), int'(best_pos[g]), e.bp);
                    check($sformatf("ch%0d_best_val", g), int'(best_val[g]), e.bv);
                    check($sformatf("ch%0d_final_pos", g), int'(pos[g]), e.bp);
                    check($sformatf("ch%0d_busy_in_done", g), int'(busy[g]), 1);
                end
            end
        end
    end

    task automatic check_zero(input int c, input string tag);
        check({tag, "_pos"}, int'(pos[c]), 0);
        check({tag, "_best_pos"}, int'(best_pos[c]), 0);
        check({tag, "_best_val"}, int'(best_val[c]), 0);
        check({tag, "_adc_req"}, int'(adc_req[c]), 0);
        check({tag, "_busy"}, int'(busy[c]), 0);
        check({tag, "_done"}, int'(done[c]), 0);
    endtask

    task automatic run_sweep(input int c, input bit hold, input int ab);
        int  bp = 0;
        int  bv = 0;
        int  n = 0;
        bit  first = 1'b1;
        for (int p = 0; p <= PM; p += (c == 0 ? 1 : 3)) begin
            q_pos[c].push_back(p);
            if (p == ab) break;
            if (first || samp[c][p] / 64 > bv / 64) begin
                bp = p;
                bv = samp[c][p];
                first = 1'b0;
            end
        end
        if (ab < 0) q_exp[c].push_back('{bp, bv});
        abort_pos[c] = ab;
        start[c] = 1'b1;
        @(negedge clk);
        if (!hold) start[c] = 1'b0;
        while (!done[c] && busy[c] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL ch%0d_timeout: sweep did not finish in 1000 cycles", c);
        end
        if (hold) begin
            @(posedge clk);
            #1 start[c] = 1'b0;
        end
        if (ab >= 0) begin
            check("abort_busy", int'(busy[c]), 0);
            check("abort_adc_req", int'(adc_req[c]), 0);
            check("abort_pos", int'(pos[c]), ab);
            check("abort_best_pos", int'(best_pos[c]), bp);
            check("abort_best_val", int'(best_val[c]), bv);
            check("abort_done", int'(done[c]), 0);
        end
        repeat (3) @(negedge clk);
        check($sformatf("ch%0d_idle_after", c), int'(busy[c]), 0);
        abort_pos[c] = -1;
    endtask

    task automatic load(input int c, input int v0, input int v1, input int v2, input int v3, input int v4);
        samp[c][0] = 12'(v0);
        samp[c][1] = 12'(v1);
        samp[c][2] = 12'(v2);
        samp[c][3] = 12'(v3);
        samp[c][4] = 12'(v4);
    endtask

    task automatic load_random(input int c, input bit coarse);
        for (int p = 0; p <= PM; p++)
            samp[c][p] = coarse ? 12'(($urandom_range(0, 3) << 6) | $urandom_range(0, 63))
                                : 12'($urandom_range(0, 4095));
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        abort_pos[0] = -1;
        abort_pos[1] = -1;
        repeat (3) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        rst_n = 1'b1;
        @(negedge clk);

        load(0, 100, 200, 300, 400, 500);
        run_sweep(0, 1'b0, -1);
        load(0, 'h0C0, 'h0FF, 'h040, 'h0C0, 'h000);
        run_sweep(0, 1'b0, -1);
        load(0, 0, 0, 0, 0, 0);
        run_sweep(0, 1'b0, -1);
        load(0, 'h300, 'h100, 'h200, 'h500, 'h400);
        run_sweep(0, 1'b0, 2);
        load_random(0, 1'b0);
        run_sweep(0, 1'b1, -1);
        for (int i = 0; i < 6; i++) begin
            load_random(0, i[0]);
            run_sweep(0, 1'b0, -1);
        end
        for (int i = 0; i < 4; i++) begin
            load_random(1, i[0]);
            run_sweep(1, 1'b0, -1);
        end

        // Asynchronous reset in the middle of a settle wait.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero(0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_busy", int'(busy[0]), 0);

        load_random(0, 1'b1);
        run_sweep(0, 1'b0, -1);
        check("ch0_q_exp_empty", q_exp[0].size(), 0);
        check("ch1_q_exp_empty", q_exp[1].size(), 0);
        check("ch0_q_pos_empty", q_pos[0].size(), 0);
        check("ch1_q_pos_empty", q_pos[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
